// File: rtl/mdio_master.sv
// Clause-22 MDIO master; MDC comes from an enable counter in the CLK_50M domain.
// Define MDIO_TA_CHECK_EN to flag reads whose second turnaround bit is high (no PHY).
module mdio_master #(
   parameter int unsigned CLK_DIV      = 25,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input  logic        CLK_50M,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        rd_err,
   output logic        MDC,
   inout  wire         MDIO
);
   localparam int unsigned N  = PREAMBLE_LEN + 32;
   localparam int unsigned DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [6:0]    BIT_LAST = 7'(N - 1);

   typedef enum logic [2:0] {IDLE, PRE, ST, OP, ADDR, TA, DATA, DONE} state_t;

   state_t        state;
   state_t        nxt_state;
   logic [6:0]    bit_cnt;
   logic [6:0]    nxt_bit;
   logic [DW-1:0] div_cnt;
   logic [31:0]   frame;
   logic [31:0]   frame_init;
   logic          is_read;
   logic          mdio_o;
   logic          oe;
   logic [15:0]   rd_shift;
   logic          ta_high;

   // Frame phase is a pure function of the bit index counted from the first preamble bit.
   function automatic state_t state_of(input logic [6:0] b);
      int k;
      k = int'(b) - int'(PREAMBLE_LEN);
      if (k < 0)        return PRE;
      else if (k < 2)   return ST;
      else if (k < 4)   return OP;
      else if (k < 14)  return ADDR;
      else if (k < 16)  return TA;
      else              return DATA;
   endfunction

   assign frame_init = {2'b01, (cmd_write ? 2'b01 : 2'b10), phy_addr, reg_addr,
                        (cmd_write ? 2'b10 : 2'b00), (cmd_write ? wr_data : 16'h0000)};

   always_comb begin
      nxt_bit   = bit_cnt + 7'd1;
      nxt_state = state_of(nxt_bit);
   end

   assign MDIO = oe ? mdio_o : 1'bz;

`ifdef MDIO_TA_CHECK_EN
   localparam logic [6:0] TA_LAST = 7'(PREAMBLE_LEN + 15);
`else
   assign ta_high = 1'b0;
   assign rd_err  = 1'b0;
`endif

   always_ff @(posedge CLK_50M or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         frame     <= '0;
         is_read   <= 1'b0;
         mdio_o    <= 1'b0;
         oe        <= 1'b0;
         MDC       <= 1'b0;
         cmd_ready <= 1'b1;
         rd_shift  <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
`ifdef MDIO_TA_CHECK_EN
         ta_high   <= 1'b0;
         rd_err    <= 1'b0;
`endif
      end else begin
         rd_valid <= 1'b0;
`ifdef MDIO_TA_CHECK_EN
         rd_err   <= 1'b0;
`endif
         case (state)
            IDLE: if (cmd_valid) begin
               cmd_ready <= 1'b0;
               is_read   <= !cmd_write;
               oe        <= 1'b1;
               bit_cnt   <= '0;
               div_cnt   <= '0;
`ifdef MDIO_TA_CHECK_EN
               ta_high   <= 1'b0;
`endif
               if (PREAMBLE_LEN == 0) begin
                  state  <= ST;
                  mdio_o <= frame_init[31];
                  frame  <= {frame_init[30:0], 1'b0};
               end else begin
                  state  <= PRE;
                  mdio_o <= 1'b1;
                  frame  <= frame_init;
               end
            end
            DONE: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + DW'(1);
               end else begin
                  div_cnt <= '0;
                  if (!MDC) begin
                     MDC <= 1'b1;
                     if (is_read && state == DATA) rd_shift <= {rd_shift[14:0], MDIO};
`ifdef MDIO_TA_CHECK_EN
                     if (is_read && bit_cnt == TA_LAST) ta_high <= MDIO;
`endif
                  end else begin
                     // End of a high phase: either start the next bit or close the frame.
                     MDC <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        state  <= DONE;
                        oe     <= 1'b0;
                        mdio_o <= 1'b0;
                        if (is_read) begin
                           rd_valid <= 1'b1;
                           rd_data  <= ta_high ? 16'hFFFF : rd_shift;
`ifdef MDIO_TA_CHECK_EN
                           rd_err   <= ta_high;
`endif
                        end
                     end else begin
                        bit_cnt <= nxt_bit;
                        state   <= nxt_state;
                        if (nxt_state == PRE) begin
                           mdio_o <= 1'b1;
                        end else begin
                           mdio_o <= frame[31];
                           frame  <= {frame[30:0], 1'b0};
                        end
                        if (is_read && (nxt_state == TA || nxt_state == DATA)) oe <= 1'b0;
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule
